glm_sbox_compress: RTL and testbench
====================================

Name: glm_sbox_compress

Overview:
- Registered compression stage directly downstream of the per-domain S-box evaluators of the first-order GLM-masked PRINCE S-box.
- Captures the NUM_DOMAINS domain outputs (s[3:0], t[3:0] each) in a glitch-barrier register layer.
- XOR-compresses them into two 4-bit shares of the S output and two of the T output, with valid/ready flow control for the round datapath.

Parameters:
- NUM_DOMAINS, 16, number of domain evaluator instances feeding the stage (power of two, ≥2).
- SEL_BIT, 3, bit of the domain index that selects the output share the domain is folded into (0 ≤ SEL_BIT < log2(NUM_DOMAINS)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  dom_in carries a complete set of domain outputs.
- in_ready  out  1  stage 1 can accept this cycle.
- dom_in  in  8*NUM_DOMAINS  domain d occupies bits [8d+7:8d] = {t3,t2,t1,t0,s3,s2,s1,s0}.
- out_valid  out  1  output shares valid.
- out_ready  in  1  consumer accepts this cycle.
- s_sh0  out  4  S-output share 0.
- s_sh1  out  4  S-output share 1.
- t_sh0  out  4  T-output share 0.
- t_sh1  out  4  T-output share 1.

Behaviour:
- Two-stage pipeline. Transfer on valid&ready at each side. Latency is exactly 2 cycles from input accept to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Stage 1 (glitch barrier):
  - reg1 holds dom_in verbatim, plus v1.
  - Loads only on in_valid & in_ready.
  - When not loading, reg1 holds its value. It is never cleared to zero, to avoid extra share transitions.
  - No combinational XOR is placed before reg1.
- Stage 2 (compression):
  - s_sh0 = XOR of s fields of all domains d with d[SEL_BIT]=0.
  - s_sh1 = same XOR over domains with d[SEL_BIT]=1.
  - t_sh0 and t_sh1 are formed the same way from the t fields.
  - The XOR is computed from reg1 and registered into reg2 (v2). Outputs are driven directly from reg2 flops.
  - No path from dom_in to any output.
- Flow control (no bubbles under continuous flow):
  - in_ready = ~v1 | ~v2 | out_ready. This is a combinational function of registered state and out_ready only; in_valid does not feed it.
  - Stage 2 loads when v1 & (~v2 | out_ready).
  - v2 clears on out_valid & out_ready with no simultaneous load.
  - v1 clears when stage 2 loads and no new input is accepted the same cycle.
  - Simultaneous stage-2 load and input accept: reg1 takes the new data, v1 stays 1.
- Backpressure:
  - With out_ready=0 and v2=1, reg2 and outputs hold stable.
  - Stage 1 can still accept one item if v1=0, then in_ready drops.
  - Outputs must not change while out_valid=1 and out_ready=0.
- Reset (asynchronous assert, any cycle including mid-transfer):
  - v1, v2, out_valid and in_ready-related state go to 0.
  - reg1, reg2, s_sh0, s_sh1, t_sh0, t_sh1 go to 0.
  - After rst_n deassertion, in_ready=1 on the first clock.
  - In-flight data is discarded; nothing is replayed.
- Width rule: all XORs are 4-bit bitwise. There is no arithmetic or carry.
- Unmasked result = s_sh0^s_sh1 (and t_sh0^t_sh1). The block never combines the two shares internally.

Test Plan:
- Reset: hold rst_n=0 with random dom_in and in_valid=1 → out_valid=0, all shares 0x0. Release → in_ready=1.
- Single item: dom_in with domain 0 s=0x5, domain 8 s=0xA, domain 15 t=0x3, all else 0; in_valid for 1 cycle, out_ready=1 → exactly 2 cycles later out_valid=1, s_sh0=0x5, s_sh1=0xA, t_sh0=0x0, t_sh1=0x3. The next cycle out_valid=0.
- Streaming: 20 back-to-back random inputs with out_ready=1 → 20 consecutive out_valid cycles after 2-cycle latency. Each output matches the reference XOR model, with no drops or duplicates.
- Backpressure: 4 inputs then out_ready=0 for 5 cycles → in_ready=0 after 2 items buffered. Outputs stay stable while stalled. On release all 4 items emerge in order.
- Simultaneous events: v2=1, out_ready=1 and in_valid=1 in the same cycle → pop, advance and accept all occur. Order is preserved and in_ready remains 1.
- Mid-operation reset: assert rst_n=0 asynchronously between edges with both stages full → out_valid falls immediately (before the next edge) and shares read 0x0. The first post-reset input appears alone after 2 cycles.

Source files
------------

// File: rtl/glm_sbox_compress_if.sv
// Handshake and share bus between the GLM S-box domain evaluators, the
// compression stage and the round datapath.
interface glm_sbox_compress_if #(
    parameter int unsigned NUM_DOMAINS = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [8*NUM_DOMAINS-1:0]   dom_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [3:0]                 s_sh0;
    logic [3:0]                 s_sh1;
    logic [3:0]                 t_sh0;
    logic [3:0]                 t_sh1;

    modport slave (
        input  in_valid, dom_in, out_ready,
        output in_ready, out_valid, s_sh0, s_sh1, t_sh0, t_sh1
    );

    modport master (
        output in_valid, dom_in, out_ready,
        input  in_ready, out_valid, s_sh0, s_sh1, t_sh0, t_sh1
    );
endinterface

// File: rtl/glm_sbox_compress.sv
// Two-stage compression of GLM-masked PRINCE S-box domain outputs: a verbatim
// glitch-barrier register followed by a registered XOR fold into two shares.
module glm_sbox_compress #(
    parameter int unsigned NUM_DOMAINS = 16,
    parameter int unsigned SEL_BIT     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    glm_sbox_compress_if.slave  io
);
    localparam int unsigned DOM_W = 8;
    localparam int unsigned SH_W  = 4;
    localparam int unsigned BUS_W = DOM_W * NUM_DOMAINS;

    logic              v1_q, v1_d;
    logic              v2_q, v2_d;
    logic [BUS_W-1:0]  reg1_q, reg1_d;
    logic [SH_W-1:0]   s0_q, s0_d, s1_q, s1_d;
    logic [SH_W-1:0]   t0_q, t0_d, t1_q, t1_d;
    logic [SH_W-1:0]   s0_x, s1_x, t0_x, t1_x;
    logic              in_ready_c;
    logic              accept;
    logic              load2;

    // Ready depends only on registered occupancy and downstream ready.
    assign in_ready_c = ~v1_q | ~v2_q | io.out_ready;
    assign accept     = io.in_valid & in_ready_c;
    assign load2      = v1_q & (~v2_q | io.out_ready);

    // Fold every domain into share 0 or 1 according to one index bit.
    always_comb begin
        s0_x = '0;
        s1_x = '0;
        t0_x = '0;
        t1_x = '0;
        for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
            if (((d >> SEL_BIT) & 32'd1) == 32'd0) begin
                s0_x = s0_x ^ reg1_q[d*DOM_W +: SH_W];
                t0_x = t0_x ^ reg1_q[d*DOM_W + SH_W +: SH_W];
            end else begin
                s1_x = s1_x ^ reg1_q[d*DOM_W +: SH_W];
                t1_x = t1_x ^ reg1_q[d*DOM_W + SH_W +: SH_W];
            end
        end
    end

    // Next state: data registers only move on a load, never get zeroed.
    always_comb begin
        v1_d   = v1_q;
        v2_d   = v2_q;
        reg1_d = reg1_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        t0_d   = t0_q;
        t1_d   = t1_q;

        if (accept) begin
            reg1_d = io.dom_in;
            v1_d   = 1'b1;
        end else if (load2) begin
            v1_d   = 1'b0;
        end

        if (load2) begin
            s0_d = s0_x;
            s1_d = s1_x;
            t0_d = t0_x;
            t1_d = t1_x;
            v2_d = 1'b1;
        end else if (v2_q & io.out_ready) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            reg1_q <= '0;
            s0_q   <= '0;
            s1_q   <= '0;
            t0_q   <= '0;
            t1_q   <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            reg1_q <= reg1_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            t0_q   <= t0_d;
            t1_q   <= t1_d;
        end
    end

    assign io.in_ready  = in_ready_c;
    assign io.out_valid = v2_q;
    assign io.s_sh0     = s0_q;
    assign io.s_sh1     = s1_q;
    assign io.t_sh0     = t0_q;
    assign io.t_sh1     = t1_q;
endmodule

// File: tb/tb_glm_sbox_compress.sv
// Directed self-checking bench for glm_sbox_compress with a cycle model of
// the two-stage handshake and a reference XOR fold.
module tb_glm_sbox_compress;
    localparam int unsigned ND  = 16;
    localparam int unsigned SEL = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    glm_sbox_compress_if #(.NUM_DOMAINS(ND)) bus ();

    glm_sbox_compress #(
        .NUM_DOMAINS(ND),
        .SEL_BIT    (SEL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic         mv1, mv2;
    logic [127:0] mreg1;
    logic [15:0]  msh;
    int           cyc = 0;
    int           pops = 0;
    int           first_pop = -1;
    int           last_pop = -1;
    logic [15:0]  popq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference fold, result packed as {t_sh1, t_sh0, s_sh1, s_sh0}.
    function automatic logic [15:0] ref_sh(input logic [127:0] dom);
        logic [3:0] s0, s1, t0, t1;
        s0 = '0; s1 = '0; t0 = '0; t1 = '0;
        for (int d = 0; d < 16; d++) begin
            logic [3:0] s, t;
            s = dom[8*d +: 4];
            t = dom[8*d+4 +: 4];
            if (d[SEL]) begin
                s1 = s1 ^ s;
                t1 = t1 ^ t;
            end else begin
                s0 = s0 ^ s;
                t0 = t0 ^ t;
            end
        end
        return {t1, t0, s1, s0};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [15:0] shares();
        return {bus.t_sh1, bus.t_sh0, bus.s_sh1, bus.s_sh0};
    endfunction

    // Called at a falling edge with inputs set; checks, advances model, returns at next falling edge.
    task automatic cycle();
        logic rdy_e, acc, ld2, pop;
        #1;
        rdy_e = !mv1 || !mv2 || bus.out_ready;
        check("in_ready", 32'(bus.in_ready), 32'(rdy_e));
        check("out_valid", 32'(bus.out_valid), 32'(mv2));
        check("shares", 32'(shares()), 32'(msh));
        acc = rst_n && bus.in_valid && rdy_e;
        ld2 = rst_n && mv1 && (!mv2 || bus.out_ready);
        pop = rst_n && mv2 && bus.out_ready;
        if (pop) begin
            pops++;
            popq.push_back(shares());
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        @(posedge clk);
        if (rst_n) begin
            if (ld2) begin
                msh = ref_sh(mreg1);
                mv2 = 1'b1;
            end else if (pop) begin
                mv2 = 1'b0;
            end
            if (acc) begin
                mreg1 = bus.dom_in;
                mv1   = 1'b1;
            end else if (ld2) begin
                mv1 = 1'b0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d_single, d_post;
        logic [127:0] items[4];
        logic [15:0]  exp_bp[4];
        int           idx;
        int           start_cyc;
        logic         adv;

        d_single = (128'h30 << 120) | (128'h0A << 64) | 128'h05;
        d_post   = (128'h01 << 96) | (128'h96 << 24);

        mv1 = 1'b0; mv2 = 1'b0; mreg1 = '0; msh = '0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b1;
        bus.dom_in    = rnd128();
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Reset held with live input traffic
        repeat (3) begin
            bus.dom_in = rnd128();
            cycle();
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("rst_release_ready", 32'(bus.in_ready), 32'd1);
        check("rst_release_shares", 32'(shares()), 32'd0);
        @(negedge clk);

        // Single item with hand-computed fold
        bus.in_valid = 1'b1;
        bus.dom_in   = d_single;
        cycle();
        bus.in_valid = 1'b0;
        bus.dom_in   = '0;
        cycle();
        #1;
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_s0", 32'(bus.s_sh0), 32'h5);
        check("single_s1", 32'(bus.s_sh1), 32'hA);
        check("single_t0", 32'(bus.t_sh0), 32'h0);
        check("single_t1", 32'(bus.t_sh1), 32'h3);
        cycle();
        #1;
        check("single_after", 32'(bus.out_valid), 32'd0);
        @(negedge clk);

        // Back-to-back stream of 20 items
        pops = 0; first_pop = -1; last_pop = -1;
        start_cyc = cyc;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.dom_in   = rnd128();
            if (i == 4) begin
                #1;
                check("simul_pop_accept", {30'd0, bus.out_valid, bus.in_ready}, 32'h3);
                #1;
            end
            cycle();
        end
        bus.in_valid = 1'b0;
        repeat (4) cycle();
        check("stream_count", 32'(pops), 32'd20);
        check("stream_latency", 32'(first_pop - start_cyc), 32'd2);
        check("stream_contig", 32'(last_pop - first_pop), 32'd19);

        // Backpressure: 5 stalled cycles, then drain in order
        popq.delete();
        for (int i = 0; i < 4; i++) begin
            items[i]  = rnd128();
            exp_bp[i] = ref_sh(items[i]);
        end
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && popq.size() < 4; c++) begin
            if (c == 5) bus.out_ready = 1'b1;
            bus.in_valid = (idx < 4);
            bus.dom_in   = (idx < 4) ? items[idx] : '0;
            if (c >= 2 && c <= 4) begin
                #1;
                check("bp_stall_ready", 32'(bus.in_ready), 32'd0);
                check("bp_hold", 32'(shares()), 32'(exp_bp[0]));
                #1;
            end
            adv = bus.in_valid && (!mv1 || !mv2 || bus.out_ready);
            cycle();
            if (adv) idx++;
        end
        bus.in_valid = 1'b0;
        check("bp_count", 32'(popq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < popq.size()) check("bp_order", 32'(popq[i]), 32'(exp_bp[i]));
        end

        // Reset asserted between edges with both stages full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.dom_in    = rnd128();
        cycle();
        bus.dom_in    = rnd128();
        cycle();
        bus.in_valid  = 1'b0;
        #1;
        check("full_before_rst", {30'd0, bus.out_valid, bus.in_ready}, 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_shares", 32'(shares()), 32'd0);
        check("midrst_ready", 32'(bus.in_ready), 32'd1);
        mv1 = 1'b0; mv2 = 1'b0; mreg1 = '0; msh = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        popq.delete();
        pops = 0; first_pop = -1; last_pop = -1;
        start_cyc = cyc;
        bus.in_valid = 1'b1;
        bus.dom_in   = d_post;
        cycle();
        bus.in_valid = 1'b0;
        repeat (4) cycle();
        check("post_rst_count", 32'(pops), 32'd1);
        check("post_rst_latency", 32'(first_pop - start_cyc), 32'd2);
        if (popq.size() > 0) check("post_rst_value", 32'(popq[0]), 32'h0916);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
